// File: rtl/spi_frame_master.sv
// Streams FRAME_WORDS 16-bit words from a 1-cycle-latency buffer out over SPI mode 0, MSB first.
// Chip select stays high across the whole frame so that the receiver rewinds its write address when cs drops.
module spi_frame_master #(
    parameter int CLK_DIV     = 2,
    parameter int FRAME_WORDS = 2048,
    parameter int CS_SETUP    = 4,
    parameter int GAP         = 8,
    parameter int CS_HOLD     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        rd_en,
    output logic [10:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HALF_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [10:0] LAST_WORD  = 11'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_HOLD
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [10:0] word_idx, word_idx_nxt;
    // Only the bits still to be sent; the current bit already sits on spi_mosi.
    logic [14:0] shreg, shreg_nxt;
    logic        sclk_nxt, mosi_nxt, cs_nxt, rd_en_nxt, busy_nxt, done_nxt;
    logic [10:0] rd_addr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            word_idx <= '0;
            shreg    <= '0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs   <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            word_idx <= word_idx_nxt;
            shreg    <= shreg_nxt;
            spi_sclk <= sclk_nxt;
            spi_mosi <= mosi_nxt;
            spi_cs   <= cs_nxt;
            rd_en    <= rd_en_nxt;
            rd_addr  <= rd_addr_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_cnt_nxt  = bit_cnt;
        word_idx_nxt = word_idx;
        shreg_nxt    = shreg;
        sclk_nxt     = spi_sclk;
        mosi_nxt     = spi_mosi;
        cs_nxt       = spi_cs;
        rd_en_nxt    = 1'b0;
        rd_addr_nxt  = rd_addr;
        busy_nxt     = busy;
        done_nxt     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt    = S_SETUP;
                    cnt_nxt      = '0;
                    word_idx_nxt = '0;
                    cs_nxt       = 1'b1;
                    busy_nxt     = 1'b1;
                    rd_en_nxt    = 1'b1;
                    rd_addr_nxt  = '0;
                end
            end
            S_SETUP, S_GAP: begin
                // Buffer data landed at least one cycle ago; load it and start the low phase of bit 15.
                if (cnt == ((state == S_SETUP) ? SETUP_LAST : GAP_LAST)) begin
                    state_nxt   = S_SHIFT;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                    mosi_nxt    = rd_data[15];
                    shreg_nxt   = rd_data[14:0];
                    sclk_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            S_SHIFT: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (!spi_sclk) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt == 4'd15) begin
                            if (word_idx == LAST_WORD) begin
                                state_nxt = S_HOLD;
                            end else begin
                                state_nxt    = S_GAP;
                                word_idx_nxt = word_idx + 11'd1;
                                rd_en_nxt    = 1'b1;
                                rd_addr_nxt  = word_idx + 11'd1;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + 4'd1;
                            mosi_nxt    = shreg[14];
                            shreg_nxt   = {shreg[13:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    cs_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    mosi_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master with a 4-word frame, a 1-cycle buffer model and an SPI receiver model.
module tb_spi_frame_master;

    localparam int FW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [15:0] rd_data = '0;
    logic        spi_sclk, spi_mosi, spi_cs, busy, done;

    spi_frame_master #(
        .CLK_DIV(2), .FRAME_WORDS(FW), .CS_SETUP(4), .GAP(8), .CS_HOLD(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem [0:FW-1];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[1:0]];

    // Receiver/monitor; recorded times are the cycle following the edge that changed the signal.
    logic        mon_clr = 1'b0;
    int          cs_hi_cnt, rises, rise_no_cs, first_rise, cs_rise, done_cnt, rx_bits;
    logic [15:0] rx_sh;
    logic [15:0] rx_words [$];
    int          word_start [$];
    logic [10:0] addr_log [$];
    logic        cs_prev = 1'b0, sclk_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            cs_hi_cnt = 0; rises = 0; rise_no_cs = 0; first_rise = -1; cs_rise = -1;
            done_cnt = 0; rx_bits = 0; rx_sh = '0;
            rx_words.delete(); word_start.delete(); addr_log.delete();
        end else begin
            if (spi_cs) cs_hi_cnt++;
            if (spi_cs && !cs_prev && cs_rise < 0) cs_rise = cyc + 1;
            if (spi_sclk && !sclk_prev) begin
                rises++;
                if (!spi_cs) rise_no_cs++;
                if (first_rise < 0) first_rise = cyc + 1;
                if (rx_bits == 0) word_start.push_back(cyc + 1);
                rx_sh = {rx_sh[14:0], spi_mosi};
                rx_bits++;
                if (rx_bits == 16) begin
                    rx_words.push_back(rx_sh);
                    rx_bits = 0;
                end
            end
            if (!spi_cs) rx_bits = 0;
            if (rd_en) addr_log.push_back(rd_addr);
            if (done) done_cnt++;
        end
        cs_prev   = spi_cs;
        sclk_prev = spi_sclk;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
    endtask

    task automatic set_mem(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    endtask

    initial begin
        int n_start;
        logic hit;

        set_mem(16'h0001, 16'h8000, 16'hFFFF, 16'h1234);
        repeat (3) tick();
        chk("rst_cs",   32'(spi_cs),   32'd0);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_rd_en", 32'(rd_en),   32'd0);
        chk("rst_addr", 32'(rd_addr),  32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_done", 32'(done),     32'd0);
        rst = 1'b0;
        tick();

        // Frame 1: word order, timing, and a stray start while busy.
        mon_clear();
        start = 1'b1;
        n_start = cyc + 1;
        tick();
        start = 1'b0;
        chk("f1_cs_on",   32'(spi_cs),  32'd1);
        chk("f1_busy_on", 32'(busy),    32'd1);
        chk("f1_rd_en",   32'(rd_en),   32'd1);
        chk("f1_addr0",   32'(rd_addr), 32'd0);
        tick();
        chk("f1_rd_en_pulse", 32'(rd_en), 32'd0);
        repeat (100) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1000, "f1");
        chk("f1_cs_off_at_done",   32'(spi_cs), 32'd0);
        chk("f1_busy_off_at_done", 32'(busy),   32'd0);
        chk("f1_cs_high_cycles", 32'(cs_hi_cnt), 32'd288);
        chk("f1_sclk_rises",     32'(rises),     32'd64);
        chk("f1_rises_no_cs",    32'(rise_no_cs), 32'd0);
        chk("f1_cs_rise_cycle",  32'(cs_rise),    32'(n_start + 1));
        chk("f1_first_rise",     32'(first_rise), 32'(n_start + 7));
        chk("f1_word_count",     32'(rx_words.size()), 32'd4);
        chk("f1_addr_count",     32'(addr_log.size()), 32'd4);
        for (int i = 0; i < FW; i++) begin
            chk($sformatf("f1_word%0d", i), 32'(rx_words[i]), 32'(mem[i]));
            chk($sformatf("f1_addr%0d", i), 32'(addr_log[i]), 32'(i));
        end
        chk("f1_pitch01", 32'(word_start[1] - word_start[0]), 32'd72);
        chk("f1_pitch23", 32'(word_start[3] - word_start[2]), 32'd72);
        repeat (30) tick();
        chk("f1_single_done", 32'(done_cnt), 32'd1);
        chk("f1_no_requeue",  32'(spi_cs),   32'd0);

        // Back-to-back frames with start held high.
        set_mem(16'hA5C3, 16'h5A3C, 16'h0F0F, 16'hF0F0);
        mon_clear();
        start = 1'b1;
        wait_done(1000, "b2b_first");
        chk("b2b_cs_gap", 32'(spi_cs), 32'd0);
        tick();
        start = 1'b0;
        chk("b2b_cs_back", 32'(spi_cs),  32'd1);
        chk("b2b_rd_en",   32'(rd_en),   32'd1);
        chk("b2b_addr0",   32'(rd_addr), 32'd0);
        wait_done(1000, "b2b_second");
        repeat (5) tick();
        chk("b2b_done_cnt",   32'(done_cnt),  32'd2);
        chk("b2b_cs_cycles",  32'(cs_hi_cnt), 32'd576);
        chk("b2b_rises",      32'(rises),     32'd128);
        chk("b2b_word_count", 32'(rx_words.size()), 32'd8);
        for (int i = 0; i < 2 * FW; i++)
            chk($sformatf("b2b_word%0d", i), 32'(rx_words[i]), 32'(mem[i % FW]));

        // Reset in the middle of word 2.
        set_mem(16'h0001, 16'h8000, 16'hFFFF, 16'h1234);
        mon_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (rises >= 40) begin
                hit = 1'b1;
                break;
            end
        end
        chk("mid_reached_word2", 32'(hit),      32'd1);
        chk("mid_pre_cs",        32'(spi_cs),   32'd1);
        chk("mid_pre_mosi",      32'(spi_mosi), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs",   32'(spi_cs),   32'd0);
        chk("mid_rst_sclk", 32'(spi_sclk), 32'd0);
        chk("mid_rst_mosi", 32'(spi_mosi), 32'd0);
        chk("mid_rst_busy", 32'(busy),     32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("mid_no_done", 32'(done_cnt), 32'd0);

        mon_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1000, "after_rst");
        chk("after_rst_words", 32'(rx_words.size()), 32'd4);
        chk("after_rst_addr0", 32'(addr_log[0]),     32'd0);
        chk("after_rst_word0", 32'(rx_words[0]),     32'(mem[0]));
        chk("after_rst_word3", 32'(rx_words[3]),     32'(mem[3]));
        chk("after_rst_rises", 32'(rises),           32'd64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
